// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: input conditioning, 11-bit frame deframing, small FIFO.
// Optional PS2_RX_INHIBIT_EN: hold the PS/2 clock low while the FIFO is full and idle.
module ps2_rx_fifo #(
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_in__clk,
   input  logic       ps2_in__data,
   output logic       ps2_out__clk,
   output logic       ps2_out__data,
   output logic       ps2_rx__valid,
   output logic [7:0] ps2_rx__data,
   output logic       ps2_rx__error,
   input  logic       ps2_rx__ready,
   output logic       ps2_rx__overflow
);

   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_CHECK   = 2'd2
   } state_t;

   // Handshake: the head entry is transferred on any cycle where valid && ready
   // are both high; data/error stay stable while valid && !ready.

   logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic          filt_clk_q, filt_clk_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          strobe_q, strobe_d;

   state_t        state_q;
   logic [3:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic          parity_q;
   logic          stop_q;
   logic [TW-1:0] tmo_cnt_q;
   logic          ovf_q;

   logic [8:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d, remain;
   logic          valid_q, valid_d;
   logic [8:0]    head_q, head_d;

   logic          fifo_full, pop, wr_en, frame_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
         filt_clk_q  <= 1'b1;
         filt_cnt_q  <= '0;
         strobe_q    <= 1'b0;
      end else begin
         clk_meta_q  <= ps2_in__clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_in__data;
         data_sync_q <= data_meta_q;
         filt_clk_q  <= filt_clk_d;
         filt_cnt_q  <= filt_cnt_d;
         strobe_q    <= strobe_d;
      end
   end

   // Any sample matching the filtered level restarts the run, so short glitches vanish.
   always_comb begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = '0;
      strobe_d   = 1'b0;
      if (clk_sync_q != filt_clk_q) begin
         if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
            filt_clk_d = clk_sync_q;
            strobe_d   = filt_clk_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign fifo_full = (count_q == CW'(FIFO_DEPTH));
   assign pop       = valid_q && ps2_rx__ready;
   assign wr_en     = (state_q == ST_CHECK) && (!fifo_full || pop);
   assign frame_err = ~(^{shift_q, parity_q}) | ~stop_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         stop_q    <= 1'b0;
         tmo_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         ovf_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (strobe_q && !data_sync_q) begin
                  state_q   <= ST_RECEIVE;
                  bit_cnt_q <= '0;
                  tmo_cnt_q <= '0;
               end
            end
            ST_RECEIVE: begin
               if (strobe_q) begin
                  tmo_cnt_q <= '0;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q < 4'd8) begin
                     shift_q <= {data_sync_q, shift_q[7:1]};
                  end else if (bit_cnt_q == 4'd8) begin
                     parity_q <= data_sync_q;
                  end else begin
                     stop_q  <= data_sync_q;
                     state_q <= ST_CHECK;
                  end
               end else begin
                  if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) tmo_cnt_q <= tmo_cnt_q + 1'b1;
                  if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) state_q <= ST_IDLE;
               end
            end
            ST_CHECK: begin
               state_q <= ST_IDLE;
               ovf_q   <= fifo_full && !pop;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {frame_err, shift_q};
   end

   // The output register is loaded with whatever will be the head after this edge,
   // including a word being written into an otherwise-empty FIFO.
   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(wr_en) - CW'(pop);
      remain   = count_q - CW'(pop);
      valid_d  = 1'b1;
      head_d   = mem_q[rd_ptr_d];
      if (remain == '0) begin
         valid_d = wr_en;
         head_d  = {frame_err, shift_q};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(wr_en);
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         if (valid_d) head_q <= head_d;
      end
   end

`ifdef PS2_RX_INHIBIT_EN
   logic out_clk_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_clk_q <= 1'b1;
      else          out_clk_q <= !(fifo_full && state_q == ST_IDLE);
   end

   assign ps2_out__clk = out_clk_q;
`else
   assign ps2_out__clk = 1'b1;
`endif

   assign ps2_out__data    = 1'b1;
   assign ps2_rx__valid    = valid_q;
   assign ps2_rx__data     = head_q[7:0];
   assign ps2_rx__error    = head_q[8];
   assign ps2_rx__overflow = ovf_q;

endmodule
